rng_byte_source: RTL and testbench

- Hardware random-byte generator that feeds the Nios subsystem's 8-bit random input PIO (`pi_random`).
- Seeded from the 32-bit random-seed output PIO and commanded through bits of the 8-bit system-control output PIO.
- Runs a 32-bit Galois LFSR and serialises 8 successive output bits into one byte per request. Optional free-running mode is supported.
- Sits between the processor's output PIOs and its random input PIO, all on the single system clock.

---
 rtl/rng_pkg.sv | 25 ++
 rtl/rng_lfsr32_step.sv | 26 ++
 rtl/rng_byte_source.sv | 143 ++++++++++++++
 tb/tb_rng_byte_source.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// Shared types and constants for the random-byte source.
// Optional ring-oscillator entropy mixing is enabled with RNG_ENTROPY_EN.
package rng_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rng_state_t;

    localparam int CTRL_SEED_LD = 0;
    localparam int CTRL_REQ     = 1;
    localparam int CTRL_CONT    = 2;

    localparam int BYTE_BITS = 8;

    localparam logic [31:0] RNG_POLY_DEFAULT = 32'h8020_0003;
    localparam logic [31:0] RNG_SEED_DEFAULT = 32'h0000_0001;

    // An all-zero LFSR would lock up, so a zero seed falls back to the default.
    function automatic logic [31:0] seed_or_default(input logic [31:0] seed,
                                                    input logic [31:0] dflt);
        return (seed == 32'h0) ? dflt : seed;
    endfunction

endpackage

// File: rtl/rng_lfsr32_step.sv
// One step of a 32-bit Galois LFSR: output bit is lfsr[0], state shifts right
// and is XORed with the polynomial mask when the output bit is set.
module rng_lfsr32_step
    import rng_pkg::*;
#(
    parameter logic [31:0] POLY_MASK = RNG_POLY_DEFAULT
) (
    input  logic [31:0] lfsr_cur,
    output logic [31:0] lfsr_nxt,
    output logic        out_bit
);

    assign out_bit = lfsr_cur[0];

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_bit
            if (gi == 31) begin : g_top
                assign lfsr_nxt[gi] = POLY_MASK[gi] & out_bit;
            end else begin : g_mid
                assign lfsr_nxt[gi] = lfsr_cur[gi+1] ^ (POLY_MASK[gi] & out_bit);
            end
        end
    endgenerate

endmodule

// File: rtl/rng_byte_source.sv
// Random-byte generator for the processor's random input PIO: a 32-bit Galois
// LFSR serialised into bytes on request. RNG_ENTROPY_EN mixes in entropy_i.
module rng_byte_source
    import rng_pkg::*;
#(
    parameter logic [31:0] SEED_DEFAULT = RNG_SEED_DEFAULT,
    parameter logic [31:0] POLY_MASK    = RNG_POLY_DEFAULT
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [31:0] seed_i,
    input  logic [7:0]  ctrl_i,
    input  logic        entropy_i,
    output logic [7:0]  random_o,
    output logic        busy_o,
    output logic        ready_o
);

    rng_state_t  state_reg, state_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic [7:0]  shreg_reg, shreg_next;
    logic [31:0] lfsr_reg, lfsr_next;
    logic [7:0]  random_reg, random_next;
    logic        ready_reg, ready_next;
    logic        pending_reg, pending_next;
    logic [1:0]  ctrl_q_reg;

    logic        seed_edge;
    logic        req_edge;
    logic        cont_mode;
    logic [31:0] step_lfsr;
    logic        step_bit;
    logic        ent_bit;
    logic [31:0] shift_lfsr;

    assign seed_edge = ctrl_i[CTRL_SEED_LD] & ~ctrl_q_reg[CTRL_SEED_LD];
    assign req_edge  = ctrl_i[CTRL_REQ] & ~ctrl_q_reg[CTRL_REQ];
    assign cont_mode = ctrl_i[CTRL_CONT];

    rng_lfsr32_step #(
        .POLY_MASK (POLY_MASK)
    ) u_step (
        .lfsr_cur (lfsr_reg),
        .lfsr_nxt (step_lfsr),
        .out_bit  (step_bit)
    );

`ifdef RNG_ENTROPY_EN
    logic [1:0] ent_sync_reg;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ent_sync_reg <= 2'b00;
        end else begin
            ent_sync_reg <= {ent_sync_reg[0], entropy_i};
        end
    end

    assign ent_bit = ent_sync_reg[1];

    logic unused_ok;
    assign unused_ok = ^ctrl_i[7:3];
`else
    // Deterministic build: entropy input is deliberately left dangling.
    assign ent_bit = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{entropy_i, ctrl_i[7:3]};
`endif

    assign shift_lfsr = step_lfsr ^ {ent_bit, 31'h0};

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= 3'd0;
            shreg_reg   <= 8'h00;
            lfsr_reg    <= SEED_DEFAULT;
            random_reg  <= 8'h00;
            ready_reg   <= 1'b0;
            pending_reg <= 1'b0;
            ctrl_q_reg  <= 2'b00;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            shreg_reg   <= shreg_next;
            lfsr_reg    <= lfsr_next;
            random_reg  <= random_next;
            ready_reg   <= ready_next;
            pending_reg <= pending_next;
            ctrl_q_reg  <= ctrl_i[1:0];
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        shreg_next   = shreg_reg;
        lfsr_next    = lfsr_reg;
        random_next  = random_reg;
        ready_next   = ready_reg;
        pending_next = pending_reg;

        if (seed_edge) begin
            // Load beats everything; a simultaneous request is remembered.
            lfsr_next    = seed_or_default(seed_i, SEED_DEFAULT);
            cnt_next     = 3'd0;
            shreg_next   = 8'h00;
            state_next   = IDLE;
            ready_next   = 1'b0;
            pending_next = req_edge;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_edge || cont_mode || pending_reg) begin
                        state_next   = SHIFT;
                        cnt_next     = 3'd0;
                        pending_next = 1'b0;
                    end
                end
                SHIFT: begin
                    lfsr_next  = shift_lfsr;
                    shreg_next = {shreg_reg[6:0], step_bit};
                    cnt_next   = cnt_reg + 3'd1;
                    if (cnt_reg == 3'(BYTE_BITS - 1)) begin
                        random_next = {shreg_reg[6:0], step_bit};
                        ready_next  = 1'b1;
                        state_next  = IDLE;
                        cnt_next    = 3'd0;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign random_o = random_reg;
    assign ready_o  = ready_reg;
    assign busy_o   = (state_reg == SHIFT);

endmodule

// File: tb/tb_rng_byte_source.sv
// Directed bench for rng_byte_source (default build, no entropy mixing).
module tb_rng_byte_source;

    localparam logic [31:0] POLY = 32'h8020_0003;

    logic        clk_clk;
    logic        reset_reset_n;
    logic [31:0] seed_i;
    logic [7:0]  ctrl_i;
    logic        entropy_i;
    logic [7:0]  random_o;
    logic        busy_o;
    logic        ready_o;

    int total;
    int bad;

    typedef struct {
        logic [7:0] ctrl;
        logic       exp_busy;
        logic       exp_ready;
        logic [7:0] exp_random;
    } vec_t;

    vec_t vecs[10];

    rng_byte_source dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .seed_i        (seed_i),
        .ctrl_i        (ctrl_i),
        .entropy_i     (entropy_i),
        .random_o      (random_o),
        .busy_o        (busy_o),
        .ready_o       (ready_o)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Independent byte model: returns {byte, lfsr after 8 steps}.
    function automatic logic [39:0] model_byte(input logic [31:0] s);
        logic [7:0] b;
        logic       o;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            o = s[0];
            s = (s >> 1) ^ (o ? POLY : 32'h0);
            b = {b[6:0], o};
        end
        return {b, s};
    endfunction

    // Called at a negedge with ctrl_i[1] already low for a cycle.
    task automatic request_byte(input string tag, input logic [7:0] exp);
        int busy_cycles;
        busy_cycles = 0;
        ctrl_i = 8'h02;
        @(negedge clk_clk);
        for (int i = 0; i < 20 && busy_o; i++) begin
            busy_cycles++;
            @(negedge clk_clk);
        end
        check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd8);
        check({tag, "_random"}, {24'h0, random_o}, {24'h0, exp});
        check({tag, "_ready"}, {31'h0, ready_o}, 32'h1);
        $display("byte %s: random=%02h busy_cycles=%0d", tag, random_o, busy_cycles);
        ctrl_i = 8'h00;
        @(negedge clk_clk);
    endtask

    initial begin
        logic [39:0] r;
        logic [31:0] model_lfsr;
        logic [7:0]  b1, b2, b3;
        int          busy_cycles;

        total = 0;
        bad   = 0;
        reset_reset_n = 1'b0;
        seed_i    = 32'h0;
        ctrl_i    = 8'h00;
        entropy_i = 1'b0;

        vecs[0] = '{8'h02, 1'b1, 1'b0, 8'h00};
        vecs[1] = '{8'h02, 1'b1, 1'b0, 8'h00};
        vecs[2] = '{8'h02, 1'b1, 1'b0, 8'h00};
        vecs[3] = '{8'h00, 1'b1, 1'b0, 8'h00};
        vecs[4] = '{8'h00, 1'b1, 1'b0, 8'h00};
        vecs[5] = '{8'h02, 1'b1, 1'b0, 8'h00};
        vecs[6] = '{8'h00, 1'b1, 1'b0, 8'h00};
        vecs[7] = '{8'h00, 1'b1, 1'b0, 8'h00};
        vecs[8] = '{8'h00, 1'b0, 1'b1, 8'hDB};
        vecs[9] = '{8'h00, 1'b0, 1'b1, 8'hDB};

        // Reset state
        repeat (2) @(negedge clk_clk);
        check("rst_random", {24'h0, random_o}, 32'h0);
        check("rst_busy",   {31'h0, busy_o},   32'h0);
        check("rst_ready",  {31'h0, ready_o},  32'h0);
        check("rst_lfsr",   dut.lfsr_reg,      32'h1);
        reset_reset_n = 1'b1;
        @(negedge clk_clk);

        // First byte from the default seed, cycle by cycle; the request
        // re-edge at vector 5 lands mid-SHIFT and must be ignored.
        for (int i = 0; i < 10; i++) begin
            ctrl_i = vecs[i].ctrl;
            @(negedge clk_clk);
            check($sformatf("vec%0d_busy", i),   {31'h0, busy_o},   {31'h0, vecs[i].exp_busy});
            check($sformatf("vec%0d_ready", i),  {31'h0, ready_o},  {31'h0, vecs[i].exp_ready});
            check($sformatf("vec%0d_random", i), {24'h0, random_o}, {24'h0, vecs[i].exp_random});
            $display("vec %0d: ctrl=%02h busy=%0b ready=%0b random=%02h", i, vecs[i].ctrl, busy_o, ready_o, random_o);
        end
        check("lfsr_after_first", dut.lfsr_reg, 32'hDB36C002);
        repeat (4) @(negedge clk_clk);
        check("no_queued_request", {31'h0, busy_o}, 32'h0);

        // Zero seed falls back to the default
        seed_i = 32'h0;
        ctrl_i = 8'h01;
        @(negedge clk_clk);
        check("zero_seed_lfsr",   dut.lfsr_reg,      32'h1);
        check("zero_seed_ready",  {31'h0, ready_o},  32'h0);
        check("zero_seed_random", {24'h0, random_o}, 32'hDB);
        check("zero_seed_busy",   {31'h0, busy_o},   32'h0);
        ctrl_i = 8'h00;
        @(negedge clk_clk);
        request_byte("zero_seed", 8'hDB);
        r = model_byte(32'hDB36C002);
        request_byte("second_byte", r[39:32]);

        // Seed load and request in the same cycle
        seed_i = 32'h1;
        ctrl_i = 8'h03;
        @(negedge clk_clk);
        check("same_cycle_idle", {31'h0, busy_o}, 32'h0);
        check("same_cycle_ready_clr", {31'h0, ready_o}, 32'h0);
        ctrl_i = 8'h02;
        @(negedge clk_clk);
        busy_cycles = 0;
        for (int i = 0; i < 20 && busy_o; i++) begin
            busy_cycles++;
            @(negedge clk_clk);
        end
        check("same_cycle_busy_cycles", 32'(busy_cycles), 32'd8);
        check("same_cycle_random", {24'h0, random_o}, 32'hDB);
        $display("byte same_cycle: random=%02h busy_cycles=%0d", random_o, busy_cycles);
        ctrl_i = 8'h00;
        @(negedge clk_clk);

        // Seed load while cnt==4 aborts the byte
        ctrl_i = 8'h01;
        @(negedge clk_clk);
        ctrl_i = 8'h00;
        @(negedge clk_clk);
        ctrl_i = 8'h02;
        @(negedge clk_clk);
        repeat (4) @(negedge clk_clk);
        check("abort_busy_before", {31'h0, busy_o}, 32'h1);
        ctrl_i = 8'h01;
        @(negedge clk_clk);
        check("abort_busy",   {31'h0, busy_o},   32'h0);
        check("abort_random", {24'h0, random_o}, 32'hDB);
        check("abort_ready",  {31'h0, ready_o},  32'h0);
        check("abort_lfsr",   dut.lfsr_reg,      32'h1);
        ctrl_i = 8'h00;
        repeat (3) @(negedge clk_clk);
        check("abort_no_restart", {31'h0, busy_o}, 32'h0);
        $display("abort: busy=%0b ready=%0b random=%02h", busy_o, ready_o, random_o);

        // Continuous mode from seed 1 for 30 cycles
        model_lfsr = 32'h1;
        r = model_byte(model_lfsr); b1 = r[39:32]; model_lfsr = r[31:0];
        r = model_byte(model_lfsr); b2 = r[39:32]; model_lfsr = r[31:0];
        r = model_byte(model_lfsr); b3 = r[39:32];
        check("model_first_byte", {24'h0, b1}, 32'hDB);
        ctrl_i = 8'h04;
        for (int k = 0; k < 30; k++) begin
            logic [7:0] exp_r;
            @(negedge clk_clk);
            exp_r = (k < 8) ? 8'hDB : (k < 17) ? b1 : (k < 26) ? b2 : b3;
            check($sformatf("cont%0d_busy", k),   {31'h0, busy_o},   {31'h0, ((k % 9) != 8)});
            check($sformatf("cont%0d_ready", k),  {31'h0, ready_o},  {31'h0, (k >= 8)});
            check($sformatf("cont%0d_random", k), {24'h0, random_o}, {24'h0, exp_r});
            $display("cont %0d: busy=%0b ready=%0b random=%02h", k, busy_o, ready_o, random_o);
        end
        ctrl_i = 8'h00;
        repeat (12) @(negedge clk_clk);

        // Asynchronous reset in the middle of SHIFT
        ctrl_i = 8'h02;
        repeat (3) @(negedge clk_clk);
        check("pre_reset_busy", {31'h0, busy_o}, 32'h1);
        #2;
        reset_reset_n = 1'b0;
        #1;
        check("async_rst_random", {24'h0, random_o}, 32'h0);
        check("async_rst_busy",   {31'h0, busy_o},   32'h0);
        check("async_rst_ready",  {31'h0, ready_o},  32'h0);
        $display("async reset: busy=%0b ready=%0b random=%02h", busy_o, ready_o, random_o);
        ctrl_i = 8'h00;
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        @(negedge clk_clk);
        request_byte("after_reset", 8'hDB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
